// File: rtl/j68_decode_rom_ld.sv
`default_nettype none
// ============================================================================
// Module   : j68_decode_rom_ld
// Brief    : Runtime-loadable J68 decode/microcode table, byte-stream loaded,
//            synchronous read with 1- or 2-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module j68_decode_rom_ld #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 36,
    parameter int LOAD_W  = 8,
    parameter int OUT_REG = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              rd_ena,
    output logic [DATA_W-1:0] q,
    input  logic [LOAD_W-1:0] ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              reload,
    output logic              rom_ready,
    output logic [15:0]       checksum
);
    localparam int c_NB    = (DATA_W + LOAD_W - 1) / LOAD_W;
    localparam int c_BI_W  = (c_NB > 1) ? $clog2(c_NB) : 1;
    localparam int c_ASM_W = c_NB * LOAD_W;
    localparam logic [c_BI_W-1:0] c_LAST_BEAT = c_BI_W'(c_NB - 1);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_waddr;
    logic [c_BI_W-1:0]   r_beat;
    logic [c_ASM_W-1:0]  r_asm;
    logic [c_ASM_W-1:0]  w_asm_next;
    logic [15:0]         r_checksum;
    logic [15:0]         w_beat_ext;
    logic [DATA_W-1:0]   mem [2**ADDR_W];
    logic [DATA_W-1:0]   r_q1;
    logic                r_en1;
    logic                w_accept;
    logic                w_last_beat;
    logic                w_final;
    logic                w_rd_clr;

    assign w_accept    = (r_state == ST_LOAD) && ld_valid;
    assign w_last_beat = (r_beat == c_LAST_BEAT);
    assign w_final     = w_accept && w_last_beat && (&r_waddr);
    // Read path is forced to zero unless both this and the next cycle are RUN.
    assign w_rd_clr    = !reset_n || (r_state != ST_RUN) || (w_next_state != ST_RUN);
    assign checksum    = r_checksum;

    generate
        if (LOAD_W >= 16) begin : g_cs_trunc
            assign w_beat_ext = ld_data[15:0];
        end else begin : g_cs_ext
            assign w_beat_ext = {{(16-LOAD_W){1'b0}}, ld_data};
        end
        if (c_ASM_W > DATA_W) begin : g_asm_pad
            logic w_unused_pad;
            assign w_unused_pad = ^w_asm_next[c_ASM_W-1:DATA_W];
        end
    endgenerate

    always_comb begin
        w_asm_next = r_asm;
        for (int k = 0; k < c_NB; k++) begin
            if (r_beat == c_BI_W'(k)) begin
                w_asm_next[k*LOAD_W +: LOAD_W] = ld_data;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        ld_ready     = 1'b0;
        rom_ready    = 1'b0;
        case (r_state)
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (w_final && !reload) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                rom_ready = 1'b1;
                if (reload) begin
                    w_next_state = ST_LOAD;
                end
            end
            default: w_next_state = ST_LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_waddr    <= '0;
            r_beat     <= '0;
            r_asm      <= '0;
            r_checksum <= '0;
        end else if (r_state == ST_RUN) begin
            if (reload) begin
                r_waddr    <= '0;
                r_beat     <= '0;
                r_checksum <= '0;
            end
        end else if (w_accept) begin
            // A reload coinciding with the final word restarts the load from scratch.
            if (w_final && reload) begin
                r_checksum <= '0;
            end else begin
                r_checksum <= r_checksum + w_beat_ext;
            end
            if (w_last_beat) begin
                r_beat  <= '0;
                r_waddr <= r_waddr + ADDR_W'(1);
            end else begin
                r_beat  <= r_beat + c_BI_W'(1);
                r_asm   <= w_asm_next;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept && w_last_beat) begin
            mem[r_waddr] <= w_asm_next[DATA_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (w_rd_clr) begin
            r_q1  <= '0;
            r_en1 <= 1'b0;
        end else begin
            r_en1 <= rd_ena;
            if (rd_ena) begin
                r_q1 <= mem[address];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] r_q2;
            always_ff @(posedge clock) begin
                if (w_rd_clr) begin
                    r_q2 <= '0;
                end else if (r_en1) begin
                    r_q2 <= r_q1;
                end
            end
            assign q = r_q2;
        end else begin : g_out_direct
            logic w_unused_en;
            assign w_unused_en = r_en1;
            assign q = r_q1;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_j68_decode_rom_ld.sv
`default_nettype none
// ============================================================================
// Module   : tb_j68_decode_rom_ld
// Brief    : Self-checking bench for j68_decode_rom_ld, both read latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_j68_decode_rom_ld;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 12;
    localparam int LOAD_W = 8;
    localparam int DEPTH  = 4;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] address;
    logic              rd_ena;
    logic [LOAD_W-1:0] ld_data;
    logic              ld_valid;
    logic              reload;
    logic [DATA_W-1:0] q0, q1;
    logic              ld_ready0, ld_ready1, rom_ready0, rom_ready1;
    logic [15:0]       cs0, cs1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]        bytes_q[$];
    logic [DATA_W-1:0] model [DEPTH];
    logic [15:0]       model_cs;
    logic [DATA_W-1:0] exp0, exp1;

    always #5 clock = ~clock;

    j68_decode_rom_ld #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_W(LOAD_W), .OUT_REG(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .address(address), .rd_ena(rd_ena), .q(q0),
        .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready0), .reload(reload),
        .rom_ready(rom_ready0), .checksum(cs0)
    );

    j68_decode_rom_ld #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_W(LOAD_W), .OUT_REG(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .address(address), .rd_ena(rd_ena), .q(q1),
        .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready1), .reload(reload),
        .rom_ready(rom_ready1), .checksum(cs1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected q: latency-1 port shows the newest issued read, latency-2 port
    // shows what the latency-1 port showed one cycle earlier.
    task automatic read_step(input logic [ADDR_W-1:0] a, input logic en);
        address = a;
        rd_ena  = en;
        tick();
        exp1 = exp0;
        if (en) exp0 = model[a];
        rd_ena = 1'b0;
    endtask

    task automatic stream(input int mode, output bit early, output bit rise, output int cycles);
        int sum;
        int v;
        int last;
        sum = 0; early = 0; rise = 0; cycles = 0;
        exp0 = '0; exp1 = '0;
        last = bytes_q.size() - 1;
        for (int i = 0; i <= last; i++) begin
            if (mode == 2) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    ld_valid = 1'b0;
                    ld_data  = 8'($urandom);
                    if (rom_ready0 || !ld_ready0) early = 1;
                    tick(); cycles++;
                end
            end
            ld_data  = bytes_q[i];
            ld_valid = 1'b1;
            if (rom_ready0 || !ld_ready0) early = 1;
            tick(); cycles++;
            ld_valid = 1'b0;
            ld_data  = 8'($urandom);
            if (i == last) rise = rom_ready0;
            else if (rom_ready0) early = 1;
            if (mode == 1) begin
                tick(); cycles++;
            end
            sum += int'(bytes_q[i]);
        end
        for (int w = 0; w < DEPTH; w++) begin
            v = int'(bytes_q[2*w]) + 256 * int'(bytes_q[2*w+1]);
            model[w] = DATA_W'(v % 4096);
        end
        model_cs = 16'(sum % 65536);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        ld_valid = 1'b0; reload = 1'b0; rd_ena = 1'b0; address = '0; ld_data = '0;
        do_reset();
        n_tests++; if (rom_ready0 !== 1'b0) begin n_fail++; $display("FAIL reset_rom_ready: got %b expected 0", rom_ready0); end
        n_tests++; if (ld_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready: got %b expected 1", ld_ready0); end
        n_tests++; if (cs0 !== 16'h0) begin n_fail++; $display("FAIL reset_checksum: got %h expected 0000", cs0); end
        n_tests++; if (q0 !== '0) begin n_fail++; $display("FAIL reset_q_lat1: got %h expected 000", q0); end
        n_tests++; if (q1 !== '0) begin n_fail++; $display("FAIL reset_q_lat2: got %h expected 000", q1); end
    endtask

    task automatic test_load_basic();
        bit early, rise; int cyc;
        bytes_q = {};
        for (int i = 0; i < 8; i++) bytes_q.push_back(8'(i + 1));
        stream(0, early, rise, cyc);
        n_tests++; if (early || !rise) begin n_fail++; $display("FAIL load_ready_timing: got early=%0d rise=%0d expected early=0 rise=1", early, rise); end
        n_tests++; if (cs0 !== 16'h0024) begin n_fail++; $display("FAIL load_checksum: got %h expected 0024", cs0); end
        n_tests++; if (rom_ready1 !== 1'b1 || cs1 !== 16'h0024) begin n_fail++; $display("FAIL load_lat2_inst: got ready=%b cs=%h expected 1 0024", rom_ready1, cs1); end
    endtask

    task automatic test_read_order();
        logic [ADDR_W-1:0] addrs [4];
        logic [DATA_W-1:0] want [4];
        addrs = '{2'd3, 2'd2, 2'd1, 2'd0};
        want  = '{12'h807, 12'h605, 12'h403, 12'h201};
        for (int i = 0; i < 4; i++) begin
            read_step(addrs[i], 1'b1);
            n_tests++; if (q0 !== want[i]) begin n_fail++; $display("FAIL read_lat1[%0d]: got %h expected %h", i, q0, want[i]); end
            if (i > 0) begin
                n_tests++; if (q1 !== want[i-1]) begin n_fail++; $display("FAIL read_lat2[%0d]: got %h expected %h", i - 1, q1, want[i-1]); end
            end
        end
        read_step(2'd1, 1'b0);
        n_tests++; if (q1 !== want[3]) begin n_fail++; $display("FAIL read_lat2[3]: got %h expected %h", q1, want[3]); end
        n_tests++; if (q0 !== want[3]) begin n_fail++; $display("FAIL read_hold_lat1: got %h expected %h", q0, want[3]); end
        read_step(2'd2, 1'b0);
        n_tests++; if (q0 !== want[3] || q1 !== want[3]) begin n_fail++; $display("FAIL read_hold_both: got %h/%h expected %h", q0, q1, want[3]); end
    endtask

    task automatic test_toggle_valid();
        bit early, rise; int cyc;
        logic [DATA_W-1:0] want [4];
        want = '{12'h201, 12'h403, 12'h605, 12'h807};
        do_reset();
        bytes_q = {};
        for (int i = 0; i < 8; i++) bytes_q.push_back(8'(i + 1));
        stream(1, early, rise, cyc);
        n_tests++; if (early || !rise || cyc != 16 || rom_ready0 !== 1'b1) begin n_fail++; $display("FAIL toggle_timing: got early=%0d rise=%0d cycles=%0d expected 0 1 16", early, rise, cyc); end
        n_tests++; if (cs0 !== 16'h0024) begin n_fail++; $display("FAIL toggle_checksum: got %h expected 0024", cs0); end
        for (int a = 0; a < 4; a++) begin
            read_step(2'(a), 1'b1);
            n_tests++; if (q0 !== want[a]) begin n_fail++; $display("FAIL toggle_word[%0d]: got %h expected %h", a, q0, want[a]); end
        end
    endtask

    task automatic test_reset_midload();
        bit early, rise; int cyc;
        logic [DATA_W-1:0] want [4];
        want = '{12'h211, 12'h413, 12'h615, 12'h817};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ld_data = 8'hA0 + 8'(i); ld_valid = 1'b1; tick();
        end
        ld_valid = 1'b0;
        do_reset();
        bytes_q = {};
        for (int i = 0; i < 8; i++) bytes_q.push_back(8'h11 + 8'(i));
        stream(0, early, rise, cyc);
        n_tests++; if (early || !rise) begin n_fail++; $display("FAIL midreset_timing: got early=%0d rise=%0d expected 0 1", early, rise); end
        n_tests++; if (cs0 !== 16'h00A4) begin n_fail++; $display("FAIL midreset_checksum: got %h expected 00a4", cs0); end
        for (int a = 0; a < 4; a++) begin
            read_step(2'(a), 1'b1);
            n_tests++; if (q0 !== want[a]) begin n_fail++; $display("FAIL midreset_word[%0d]: got %h expected %h", a, q0, want[a]); end
        end
    endtask

    task automatic test_reload();
        bit early, rise; int cyc;
        logic [15:0] cs_before;
        cs_before = model_cs;
        for (int i = 0; i < 4; i++) begin
            ld_data = 8'($urandom); ld_valid = 1'b1; tick();
        end
        ld_valid = 1'b0;
        n_tests++; if (cs0 !== cs_before || ld_ready0 !== 1'b0) begin n_fail++; $display("FAIL run_ignores_beats: got cs=%h ld_ready=%b expected %h 0", cs0, ld_ready0, cs_before); end
        for (int a = 0; a < 4; a++) begin
            read_step(2'(a), 1'b1);
            n_tests++; if (q0 !== exp0) begin n_fail++; $display("FAIL run_image[%0d]: got %h expected %h", a, q0, exp0); end
        end
        reload = 1'b1; rd_ena = 1'b1; address = 2'd3;
        tick();
        reload = 1'b0; rd_ena = 1'b0;
        n_tests++; if (rom_ready0 !== 1'b0 || ld_ready0 !== 1'b1 || cs0 !== 16'h0) begin n_fail++; $display("FAIL reload_state: got ready=%b ld_ready=%b cs=%h expected 0 1 0000", rom_ready0, ld_ready0, cs0); end
        n_tests++; if (q0 !== '0 || q1 !== '0) begin n_fail++; $display("FAIL reload_q_zero: got %h/%h expected 000/000", q0, q1); end
        bytes_q = {};
        for (int i = 0; i < 8; i++) bytes_q.push_back(8'($urandom));
        stream(2, early, rise, cyc);
        n_tests++; if (early || !rise) begin n_fail++; $display("FAIL reload_timing: got early=%0d rise=%0d expected 0 1", early, rise); end
        n_tests++; if (cs0 !== model_cs) begin n_fail++; $display("FAIL reload_checksum: got %h expected %h", cs0, model_cs); end
        for (int a = 0; a < 4; a++) begin
            read_step(2'(a), 1'b1);
            n_tests++; if (q0 !== exp0) begin n_fail++; $display("FAIL reload_word[%0d]: got %h expected %h", a, q0, exp0); end
        end
    endtask

    task automatic test_reload_final();
        bit early, rise; int cyc;
        reload = 1'b1; tick(); reload = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ld_data = 8'($urandom); ld_valid = 1'b1;
            reload = (i == 7);
            tick();
        end
        ld_valid = 1'b0; reload = 1'b0;
        n_tests++; if (rom_ready0 !== 1'b0 || ld_ready0 !== 1'b1 || cs0 !== 16'h0) begin n_fail++; $display("FAIL final_reload_state: got ready=%b ld_ready=%b cs=%h expected 0 1 0000", rom_ready0, ld_ready0, cs0); end
        bytes_q = {};
        for (int i = 0; i < 8; i++) bytes_q.push_back(8'($urandom));
        stream(0, early, rise, cyc);
        n_tests++; if (early || !rise) begin n_fail++; $display("FAIL final_reload_restart: got early=%0d rise=%0d expected 0 1", early, rise); end
        n_tests++; if (cs0 !== model_cs) begin n_fail++; $display("FAIL final_reload_checksum: got %h expected %h", cs0, model_cs); end
        for (int a = 3; a >= 0; a--) begin
            read_step(2'(a), 1'b1);
            n_tests++; if (q0 !== exp0) begin n_fail++; $display("FAIL final_reload_word[%0d]: got %h expected %h", a, q0, exp0); end
        end
    endtask

    task automatic test_random_traffic();
        bit early, rise; int cyc;
        for (int r = 0; r < 3; r++) begin
            reload = 1'b1; tick(); reload = 1'b0;
            bytes_q = {};
            for (int i = 0; i < 8; i++) bytes_q.push_back(8'($urandom));
            stream(2, early, rise, cyc);
            n_tests++; if (early || !rise || cs0 !== model_cs) begin n_fail++; $display("FAIL random_load[%0d]: got early=%0d rise=%0d cs=%h expected 0 1 %h", r, early, rise, cs0, model_cs); end
            for (int s = 0; s < 30; s++) begin
                read_step(2'($urandom), 1'($urandom));
                n_tests++; if (q0 !== exp0) begin n_fail++; $display("FAIL random_lat1[%0d.%0d]: got %h expected %h", r, s, q0, exp0); end
                n_tests++; if (q1 !== exp1) begin n_fail++; $display("FAIL random_lat2[%0d.%0d]: got %h expected %h", r, s, q1, exp1); end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; address = '0; rd_ena = 1'b0; ld_data = '0; ld_valid = 1'b0; reload = 1'b0;
        exp0 = '0; exp1 = '0; model_cs = '0;
        test_reset();
        test_load_basic();
        test_read_order();
        test_toggle_valid();
        test_reset_midload();
        test_reload();
        test_reload_final();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule
`default_nettype wire

// File: doc/j68_decode_rom_ld.md
# j68_decode_rom_ld

Parametrised, runtime-loadable successor to the fixed J68 decode/microcode ROM. It holds a 2^ADDR_W x DATA_W table in block RAM. The table is loaded after reset, or on request, from a narrow byte stream driven by the host/boot controller. Once loaded, it serves synchronous reads to the J68 decoder with selectable latency of 1 or 2 cycles. A ready flag and a load checksum let the core be held in reset until the table is valid.

## Interface
Parameters:
- ADDR_W, 8, table address width; depth = 2^ADDR_W words.
- DATA_W, 36, table word width.
- LOAD_W, 8, load-stream width; NB = ceil(DATA_W/LOAD_W) beats per word.
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.

Ports:
- clock, in, 1, single clock; all logic on rising edge.
- reset_n, in, 1, synchronous active-low reset.
- address, in, ADDR_W, read address.
- rd_ena, in, 1, read enable; address sampled when high.
- q, out, DATA_W, read data.
- ld_data, in, LOAD_W, load beat.
- ld_valid, in, 1, beat valid.
- ld_ready, out, 1, block accepts beats.
- reload, in, 1, single-cycle request to restart loading.
- rom_ready, out, 1, table fully loaded, reads valid.
- checksum, out, 16, modulo-2^16 sum of all beats accepted in the current load.

## Operation
- States: LOAD, RUN. Reset (reset_n=0 on a clock edge) enters LOAD.
- Reset also clears the write address, beat index and assembly register.
- Reset sets checksum = 0, q = 0 and rom_ready = 0.
- Memory contents are not cleared by reset.
- Reset mid-load discards the partial load; the next load restarts at address 0, beat 0.
- LOAD:
  - ld_ready = 1 (decoded from the state, no registered delay).
  - A beat is accepted on each edge where ld_valid & ld_ready.
  - Beat k (0..NB-1) fills assembly bits [k*LOAD_W +: LOAD_W], little-endian. Bits of the last beat above DATA_W are discarded.
  - checksum += zero-extended ld_data for every accepted beat.
  - On the edge accepting beat NB-1, the assembled word (including the final beat) is written to the write address. The write address then increments and the beat index returns to 0.
  - When the word at address 2^ADDR_W-1 is written, the write address wraps to 0 and the state moves to RUN.
  - Reads are ignored in LOAD; q holds 0.
- RUN:
  - ld_ready = 0; beats are ignored and checksum is frozen.
  - rd_ena=1 reads mem[address]. When rd_ena=0, q holds its last value.
- reload:
  - In RUN, reload=1 moves to LOAD on the next edge. It clears checksum, the write address and the beat index, and drops rom_ready.
  - reload in LOAD is ignored; the load in progress continues.
  - reload in the same cycle as the final-word write wins: the next state is LOAD, with counters cleared.

## Timing
- Load throughput: 1 beat per clock; a full load takes NB*2^ADDR_W accepted beats.
- rom_ready = 1 from the cycle after the final word is written.
- The earliest valid read is issued in the cycle rom_ready is 1.
- OUT_REG=0: q is valid on the edge after rd_ena/address are sampled (latency 1).
- OUT_REG=1: q is valid one cycle later (latency 2); both stages hold when rd_ena=0 on the first stage.
- On reload, rom_ready falls on the same edge that LOAD is entered.
- Read/write collisions cannot occur, because reads and writes are mutually exclusive by state.

## Test plan
1. ADDR_W=2, DATA_W=12, LOAD_W=8 (NB=2); stream bytes 0x01..0x08 one per cycle.
   - rom_ready rises the cycle after the 8th beat.
   - Words are mem[0]=0x201, mem[1]=0x403, mem[2]=0x605, mem[3]=0x807 (upper nibble discarded).
   - checksum = 0x0024.
2. After load, OUT_REG=0, read addresses 3,2,1,0 on consecutive cycles.
   - q = 0x807, 0x605, 0x403, 0x201, each one cycle after its address.
   - Repeat with OUT_REG=1: same values, each two cycles after its address.
3. Toggle ld_valid 1/0 every cycle during the load.
   - Same memory image and checksum as scenario 1.
   - rom_ready rises after 16 cycles of streaming.
4. Assert reset_n=0 after 3 beats, then stream 0x11..0x18.
   - mem[0]=0x211, mem[1]=0x413, mem[2]=0x615, mem[3]=0x817.
   - checksum = 0x00A4; no stale bytes from before the reset.
5. In RUN, pulse reload.
   - rom_ready=0 and ld_ready=1 next cycle; checksum = 0; beats are accepted again.
   - Beats sent in RUN before the reload changed nothing.
6. Assert reload in the cycle of the final beat.
   - State returns to LOAD with write address 0 and checksum 0; rom_ready stays 0.
